// File: rtl/cache_mem_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_pkg
// Shared types and default sizes for the data-cache main-memory responder.
//   DEF_WORD_WIDTH  : default bits per word
//   DEF_BLOCK_WORDS : default words per cache block
//   block_t         : one cache block at the default sizes
//   state_t         : responder FSM states
//   op_t            : operation latched at request acceptance
// -----------------------------------------------------------------------------
package cache_mem_pkg;

    localparam int DEF_WORD_WIDTH  = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_BLOCK_WIDTH = DEF_WORD_WIDTH * DEF_BLOCK_WORDS;

    typedef logic [DEF_BLOCK_WIDTH-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage : cache_mem_pkg

// File: rtl/mem_block_array.sv
// -----------------------------------------------------------------------------
// mem_block_array
// Synchronous single-port block storage with a one-cycle read.
// Ports:
//   clk   in  clock
//   we    in  write enable; wdata is stored at idx on the rising edge
//   idx   in  block index
//   wdata in  block to store
//   rdata out block at idx, registered on every rising edge (read-first)
// -----------------------------------------------------------------------------
module mem_block_array #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; clearing a RAM array costs a write port
    // per word and the contents are defined by the first write anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule : mem_block_array

// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
// Main-memory responder below the data cache. Services block refills (read)
// and dirty-block write-backs (write) over the busywait handshake with a fixed
// access latency.
// Ports:
//   clk           in  clock
//   reset         in  synchronous, active-high reset
//   mem_read      in  block read request, held until busywait is seen low
//   mem_write     in  block write request, same holding rule
//   mem_address   in  block address (only the low log2(MEM_DEPTH) bits used)
//   mem_writedata in  block to write
//   mem_readdata  out registered read block, valid in the RESP cycle and held
//                     until the next read completes
//   mem_busywait  out combinational; high while a request is pending/in service
// -----------------------------------------------------------------------------
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int ADDR_WIDTH  = 28,
    parameter int MEM_DEPTH   = 256,
    parameter int LATENCY     = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [ADDR_WIDTH-1:0]             mem_address,
    input  logic [WORD_WIDTH*BLOCK_WORDS-1:0] mem_writedata,
    output logic [WORD_WIDTH*BLOCK_WORDS-1:0] mem_readdata,
    output logic                              mem_busywait
);

    localparam int BLOCK_W = WORD_WIDTH * BLOCK_WORDS;
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    op_t                op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] wdata_q;

    logic               req;
    logic               access;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [BLOCK_W-1:0] ram_rdata;

    assign req    = mem_read | mem_write;
    assign access = (state == BUSY) && (cnt == '0);

    // An aborted write (reset in the access cycle) must not reach the array.
    assign ram_we = access && (op_q == OP_WRITE) && !reset;

    // In IDLE the array is addressed straight from the request so the block
    // is already sitting in ram_rdata one edge after acceptance; this keeps
    // LATENCY=1 reads correct. In BUSY the latched index holds it stable.
    assign ram_idx = (state == IDLE) ? mem_address[IDX_W-1:0] : idx_q;

    assign mem_busywait = !reset && ((state == BUSY) || ((state == IDLE) && req));

    // Upper address bits only select beyond the modelled depth; they wrap.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_address[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    mem_block_array #(
        .DATA_W (BLOCK_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= OP_READ;
            idx_q        <= '0;
            wdata_q      <= '0;
            mem_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= BUSY;
                        cnt     <= CNT_W'(LATENCY - 1);
                        // A write wins when both requests are raised together.
                        op_q    <= mem_write ? OP_WRITE : OP_READ;
                        idx_q   <= mem_address[IDX_W-1:0];
                        wdata_q <= mem_writedata;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (op_q == OP_READ) begin
                            mem_readdata <= ram_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                // The request is never accepted on the RESP->IDLE edge; a
                // still-held request is taken up as a new one from IDLE.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule : cache_mem_responder

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;
    import cache_mem_pkg::*;

    localparam int LAT = 5;

    localparam block_t D1   = 128'h44443333_22221111_00000000_DEADBEEF;
    localparam block_t D6   = 128'h66666666_77777777_88888888_99999999;
    localparam block_t A5   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam block_t DOLD = 128'h0BADF00D_0BADF00D_CAFEBABE_12345678;
    localparam block_t DNEW = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam block_t DRW  = 128'h1234;
    localparam block_t DL1  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_read, mem_write, mem_busywait;
    logic [27:0] mem_address;
    block_t      mem_writedata, mem_readdata;

    logic        l1_reset, l1_read, l1_write, l1_busywait;
    logic [27:0] l1_address;
    block_t      l1_writedata, l1_readdata;

    cache_mem_responder #(.LATENCY(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    cache_mem_responder #(.LATENCY(1)) dut_l1 (
        .clk           (clk),
        .reset         (l1_reset),
        .mem_read      (l1_read),
        .mem_write     (l1_write),
        .mem_address   (l1_address),
        .mem_writedata (l1_writedata),
        .mem_readdata  (l1_readdata),
        .mem_busywait  (l1_busywait)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Counts busy cycles (sampled on falling edges) until busywait drops.
    // Optionally changes the address after change_at busy cycles.
    task automatic wait_resp(input int change_at, input logic [27:0] new_addr, output int busy);
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mem_busywait) return;
            busy++;
            if (busy == change_at) mem_address = new_addr;
        end
        check("resp_timeout", 1, 0);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [27:0] a, input block_t d,
                          input string name, output block_t rdata, output int busy);
        @(posedge clk);
        #1;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
        @(negedge clk);
        check({name, " idle_busywait"}, mem_busywait, 1);
        wait_resp(0, '0, busy);
        rdata     = mem_readdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic l1_req(input logic rd, input logic wr, input logic [27:0] a, input block_t d,
                          output block_t rdata, output int busy);
        @(posedge clk);
        #1;
        l1_read      = rd;
        l1_write     = wr;
        l1_address   = a;
        l1_writedata = d;
        busy = 0;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!l1_busywait) break;
            busy++;
        end
        rdata    = l1_readdata;
        l1_read  = 1'b0;
        l1_write = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [27:0] addr;
        block_t      wdata;
        block_t      exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        block_t rd;
        int     busy;

        vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 28'h010, wdata: D1,   exp_rd: '0};
        vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 28'h010, wdata: '0,   exp_rd: D1};
        vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 28'h006, wdata: D6,   exp_rd: D1};
        vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 28'h105, wdata: A5,   exp_rd: D1};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 28'h005, wdata: '0,   exp_rd: A5};
        vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 28'h006, wdata: '0,   exp_rd: D6};
        vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 28'h105, wdata: '0,   exp_rd: A5};
        vecs[7] = '{rd: 1'b0, wr: 1'b1, addr: 28'h030, wdata: DOLD, exp_rd: A5};

        // Reset with a request held: busywait stays low, readdata cleared.
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        mem_address = 28'h010; mem_writedata = '0;
        l1_reset = 1'b1; l1_read = 1'b0; l1_write = 1'b0;
        l1_address = '0; l1_writedata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busywait", mem_busywait, 0);
        check("reset_readdata", mem_readdata, 0);
        check("l1_reset_readdata", l1_readdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_read = 1'b0; l1_reset = 1'b0;
        @(negedge clk);
        check("idle_noreq_busywait", mem_busywait, 0);

        // Table: write/read, wrap-around, readdata hold across writes.
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   $sformatf("vec%0d", i), rd, busy);
            check($sformatf("vec%0d busy_cycles", i), busy, LAT);
            check($sformatf("vec%0d readdata", i), rd, vecs[i].exp_rd);
        end

        // Simultaneous read+write: write serviced, readdata untouched.
        do_req(1'b1, 1'b1, 28'h020, DRW, "rw_both", rd, busy);
        check("rw_both busy_cycles", busy, LAT);
        check("rw_both readdata_held", rd, A5);
        do_req(1'b1, 1'b0, 28'h020, '0, "rw_readback", rd, busy);
        check("rw_readback readdata", rd, DRW);

        // Reset on the third BUSY cycle of a write to 0x30.
        @(posedge clk);
        #1;
        mem_write = 1'b1; mem_address = 28'h030; mem_writedata = DNEW;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst busywait", mem_busywait, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("midrst idle_busywait", mem_busywait, 0);
        check("midrst readdata", mem_readdata, 0);
        do_req(1'b1, 1'b0, 28'h030, '0, "midrst_read", rd, busy);
        check("midrst_read busy_cycles", busy, LAT);
        check("midrst_read readdata_old", rd, DOLD);

        // Back-to-back: read held through RESP, then re-accepted from IDLE.
        @(posedge clk);
        #1;
        mem_read = 1'b1; mem_address = 28'h010;
        @(negedge clk);
        check("b2b first idle_busywait", mem_busywait, 1);
        wait_resp(0, '0, busy);
        check("b2b first busy_cycles", busy, LAT);
        check("b2b first readdata", mem_readdata, D1);
        mem_address = 28'h005;
        @(negedge clk);
        check("b2b reaccept busywait", mem_busywait, 1);
        // Address moves to 0x006 mid-BUSY; the latched 0x005 must win.
        wait_resp(2, 28'h006, busy);
        check("b2b second busy_cycles", busy, LAT);
        check("b2b second readdata", mem_readdata, A5);
        mem_read = 1'b0;

        // LATENCY=1 build: one BUSY cycle per access.
        l1_req(1'b0, 1'b1, 28'h003, DL1, rd, busy);
        check("l1 write busy_cycles", busy, 1);
        l1_req(1'b1, 1'b0, 28'h003, '0, rd, busy);
        check("l1 read busy_cycles", busy, 1);
        check("l1 read readdata", rd, DL1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_mem_responder
